pq_multibank_buffer: RTL and testbench
======================================

// Module: pq_multibank_buffer
// PURPOSE
//  Parametrised N-bank ping-pong (round-robin) buffer; generalises the 2-bank pq_buffer.
//  Writer streams frames into the current fill bank with valid/ready handshake and commits them.
//  Reader randomly addresses the oldest committed bank and releases it when done.
//  Bank hand-over is tracked internally, so no external ctrl toggle is needed.
//  Sits between a frame producer (e.g. spike/feature generator) and a compute core reading by address.
// PARAMETERS
//  DATA_WIDTH  8  word width
//  ADDR_WIDTH  4  per-bank address width; DEPTH = 2**ADDR_WIDTH words per bank
//  NUM_BANKS   2  bank count, >=2; one sp_ram instance per bank
//  CNT_W       $clog2(NUM_BANKS+1)  width of bank_cnt (localparam)
// PORTS
//  clk            in   1           clock, all logic on posedge
//  rst_n          in   1           synchronous active-low reset
//  wr_valid       in   1           write word present
//  wr_ready       out  1           a fill bank is available
//  wr_data        in   DATA_WIDTH  write word
//  wr_last        in   1           accepted word is last of frame -> commit bank
//  rd_bank_valid  out  1           >=1 committed bank available to read
//  rd_en          in   1           read request
//  rd_addr        in   ADDR_WIDTH  word address within current read bank
//  rd_done        in   1           release current read bank (1-cycle pulse)
//  rd_data        out  DATA_WIDTH  read data
//  rd_data_valid  out  1           rd_data valid
//  bank_cnt       out  CNT_W       number of committed, unreleased banks
//  rd_len         out  ADDR_WIDTH+1  word count of read bank (PQ_BUF_WLEN_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wr_bank=rd_bank=0, wr_ptr=0, bank_cnt=0, rd_data=0, rd_data_valid=0,
//    rd_len=0; contents logically discarded (RAM not cleared). Mid-frame reset drops partial frame.
//  - wr_ready = (bank_cnt < NUM_BANKS), combinational from registered state; forced 0 while rst_n=0.
//  - Accept = wr_valid & wr_ready: mem[wr_bank][wr_ptr] <= wr_data; wr_ptr++.
//  - Commit on accept with wr_last=1 OR wr_ptr==DEPTH-1 (auto-commit on full bank): wr_ptr<=0,
//    wr_bank <= (wr_bank+1) mod NUM_BANKS, bank_cnt++. Minimum frame = 1 word.
//  - wr_valid while wr_ready=0: no write, no state change; wr_data/wr_last ignored.
//  - rd_bank_valid = (bank_cnt != 0). Read bank = rd_bank (oldest committed, FIFO order).
//  - rd_en & rd_bank_valid: RAM read mem[rd_bank][rd_addr]; rd_data/rd_data_valid appear 2 cycles
//    later (RAM register + output mux register). rd_en with rd_bank_valid=0 ignored, no valid pulse.
//  - Reads of addresses beyond committed length return stale data; no error.
//  - rd_done & rd_bank_valid: rd_bank <= (rd_bank+1) mod NUM_BANKS, bank_cnt--. Ignored if no bank.
//  - rd_en and rd_done same cycle: read uses current rd_bank, then release; data still returned.
//  - Reads issued before release return correct data: freed bank cannot be written before next edge.
//  - Commit and release same cycle: bank_cnt unchanged, both pointers advance.
//  - Full (bank_cnt==NUM_BANKS): wr_ready=0 until a rd_done; release and new accept may not share
//    a cycle (wr_ready reflects pre-edge count).
//  - Pointer wrap: wr_bank/rd_bank wrap NUM_BANKS-1 -> 0, also for non-power-of-2 NUM_BANKS.
// CONFIGURATION
//  PQ_BUF_WLEN_EN defined: per-bank length register (ADDR_WIDTH+1 bits) written at commit with
//    wr_ptr+1; rd_len = length of rd_bank, 0 when rd_bank_valid=0; reset 0.
//  PQ_BUF_WLEN_EN undefined: no length storage, rd_len port absent.
// TESTING (NUM_BANKS=2, ADDR_WIDTH=4, DATA_WIDTH=8)
//  1. Write 5 words 0x10..0x14, wr_last on 0x14 -> bank_cnt=1, rd_bank_valid=1; rd_addr 0..4
//     -> rd_data 0x10..0x14, each 2 cycles after rd_en; rd_len=5 (WLEN_EN).
//  2. Commit 2 frames without rd_done -> bank_cnt=2, wr_ready=0; wr_valid held, no write; one rd_done
//     -> bank_cnt=1, wr_ready=1 next cycle.
//  3. Stream 16 words without wr_last -> auto-commit after word 15, wr_ptr=0, rd_len=16.
//  4. Commit on the same cycle as rd_done with bank_cnt=1 -> bank_cnt stays 1, rd_bank advances.
//  5. rd_en+rd_done same cycle at rd_addr=3 -> data of old bank addr 3 returned, bank released.
//  6. rst_n=0 mid-frame after 7 words -> all outputs at reset values, bank_cnt=0, next frame
//     starts at bank 0 addr 0.

Source files
------------

// File: rtl/pq_multibank_buffer.sv
// pq_multibank_buffer: N-bank round-robin frame buffer with one single-port RAM per bank.
// Optional feature macro: PQ_BUF_WLEN_EN adds per-bank frame length storage and the rd_len port.

module pq_sp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Single port: the top never writes and reads the same bank in one cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end else if (en) begin
      rdata <= mem_r[addr];
    end
  end
endmodule

module pq_multibank_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_BANKS  = 2,
  localparam int CNT_W     = $clog2(NUM_BANKS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  rd_bank_valid,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [CNT_W-1:0]      bank_cnt
`ifdef PQ_BUF_WLEN_EN
  ,
  output logic [ADDR_WIDTH:0]   rd_len
`endif
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic [BANK_W-1:0]     wr_bank_r;
  logic [BANK_W-1:0]     rd_bank_r;
  logic [BANK_W-1:0]     rd_sel_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [CNT_W-1:0]      bank_cnt_r;
  logic                  rd_pend_r;
  logic                  rd_data_valid_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic [DATA_WIDTH-1:0] rd_mux_s;
  logic                  accept_s;
  logic                  commit_s;
  logic                  release_s;
  logic                  rd_fire_s;
  logic                  ptr_full_s;
  logic [DATA_WIDTH-1:0] ram_q [NUM_BANKS];

  // Round-robin successor; explicit compare so non-power-of-2 bank counts wrap correctly
  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] bank);
    if (bank == BANK_W'(NUM_BANKS - 1)) begin
      next_bank = {BANK_W{1'b0}};
    end else begin
      next_bank = bank + BANK_W'(1);
    end
  endfunction

  assign wr_ready      = rst_n & (bank_cnt_r < CNT_W'(NUM_BANKS));
  assign rd_bank_valid = (bank_cnt_r != {CNT_W{1'b0}});
  assign bank_cnt      = bank_cnt_r;
  assign rd_data       = rd_data_r;
  assign rd_data_valid = rd_data_valid_r;

  // Handshake decode
  always_comb begin
    accept_s   = wr_valid & wr_ready;
    ptr_full_s = (wr_ptr_r == {ADDR_WIDTH{1'b1}});
    commit_s   = accept_s & (wr_last | ptr_full_s);
    release_s  = rst_n & rd_done & rd_bank_valid;
    rd_fire_s  = rst_n & rd_en & rd_bank_valid;
  end

  // Fill-side pointers: word pointer and current fill bank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
      wr_bank_r <= {BANK_W{1'b0}};
    end else if (commit_s) begin
      wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
      wr_bank_r <= next_bank(wr_bank_r);
    end else if (accept_s) begin
      wr_ptr_r  <= wr_ptr_r + ADDR_WIDTH'(1);
    end
  end

  // Read-side bank pointer, advanced on release
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_r <= {BANK_W{1'b0}};
    end else if (release_s) begin
      rd_bank_r <= next_bank(rd_bank_r);
    end
  end

  // Committed-bank counter; simultaneous commit and release cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case ({commit_s, release_s})
        2'b10:   bank_cnt_r <= bank_cnt_r + CNT_W'(1);
        2'b01:   bank_cnt_r <= bank_cnt_r - CNT_W'(1);
        default: bank_cnt_r <= bank_cnt_r;
      endcase
    end
  end

  // Read pipeline: bank select travels with the RAM read, then the output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend_r       <= 1'b0;
      rd_sel_r        <= {BANK_W{1'b0}};
      rd_data_valid_r <= 1'b0;
      rd_data_r       <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_pend_r       <= rd_fire_s;
      rd_data_valid_r <= rd_pend_r;
      if (rd_fire_s) begin
        rd_sel_r <= rd_bank_r;
      end
      if (rd_pend_r) begin
        rd_data_r <= rd_mux_s;
      end
    end
  end

  // AND-OR output mux over bank read ports
  always_comb begin
    rd_mux_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) begin
      rd_mux_s = rd_mux_s | (ram_q[i] & {DATA_WIDTH{rd_sel_r == BANK_W'(i)}});
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic                  we_s;
    logic                  en_s;
    logic [ADDR_WIDTH-1:0] addr_s;

    assign we_s   = accept_s & (wr_bank_r == BANK_W'(g));
    assign en_s   = rd_fire_s & (rd_bank_r == BANK_W'(g));
    assign addr_s = we_s ? wr_ptr_r : rd_addr;

    pq_sp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk   (clk),
      .we    (we_s),
      .en    (en_s),
      .addr  (addr_s),
      .wdata (wr_data),
      .rdata (ram_q[g])
    );
  end

`ifdef PQ_BUF_WLEN_EN
  logic [ADDR_WIDTH:0] len_r [NUM_BANKS];

  // Per-bank frame length captured at commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        len_r[i] <= {(ADDR_WIDTH + 1){1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (commit_s && (wr_bank_r == BANK_W'(i))) begin
          len_r[i] <= {1'b0, wr_ptr_r} + (ADDR_WIDTH + 1)'(1);
        end
      end
    end
  end

  // Length of the current read bank, zero when nothing is committed
  always_comb begin
    rd_len = {(ADDR_WIDTH + 1){1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) begin
      rd_len = rd_len | (len_r[i] & {(ADDR_WIDTH + 1){rd_bank_valid && (rd_bank_r == BANK_W'(i))}});
    end
  end
`else
  // Without the length feature the frame length is not retained.
`endif

endmodule

// File: tb/tb_pq_multibank_buffer.sv
// Self-checking bench for pq_multibank_buffer (2 banks x 16 words x 8 bits).
// A frame-level reference model predicts counts, flow control and read data.

module tb_pq_multibank_buffer;
  localparam int NB    = 2;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          rd_bank_valid;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [1:0]    bank_cnt;
`ifdef PQ_BUF_WLEN_EN
  logic [AW:0]   rd_len;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] m_mem   [NB][DEPTH];
  bit            m_known [NB][DEPTH];
  int            m_len   [NB];
  int            m_wb = 0, m_rb = 0, m_wp = 0, m_cnt = 0;
  bit            p1_v = 0, p1_k = 0, e_dv = 0, e_k = 0;
  logic [DW-1:0] p1_d = '0, e_d = '0;

  always #5 clk = ~clk;

  pq_multibank_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .wr_last(wr_last), .rd_bank_valid(rd_bank_valid), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data), .rd_data_valid(rd_data_valid), .bank_cnt(bank_cnt)
`ifdef PQ_BUF_WLEN_EN
    , .rd_len(rd_len)
`endif
  );

  // Advance one clock; the model applies the buffer rules to the inputs present at the edge.
  task automatic tick();
    bit acc, cmt, rel, fire, rk;
    logic [DW-1:0] rv;
    fire = rst_n && rd_en && (m_cnt != 0);
    rv   = m_mem[m_rb][rd_addr];
    rk   = m_known[m_rb][rd_addr];
    acc  = rst_n && wr_valid && (m_cnt < NB);
    cmt  = acc && (wr_last || (m_wp == DEPTH - 1));
    rel  = rst_n && rd_done && (m_cnt != 0);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_wb = 0; m_rb = 0; m_wp = 0; m_cnt = 0;
      for (int b = 0; b < NB; b++) m_len[b] = 0;
      p1_v = 0; e_dv = 0; e_d = '0; e_k = 1;
    end else begin
      e_dv = p1_v;
      if (p1_v) begin e_d = p1_d; e_k = p1_k; end
      p1_v = fire; p1_d = rv; p1_k = rk;
      if (acc) begin
        m_mem[m_wb][m_wp] = wr_data;
        m_known[m_wb][m_wp] = 1;
        if (cmt) begin
          m_len[m_wb] = m_wp + 1;
          m_wp = 0;
          m_wb = (m_wb + 1) % NB;
        end else begin
          m_wp = m_wp + 1;
        end
      end
      if (rel) m_rb = (m_rb + 1) % NB;
      if (cmt && !rel) m_cnt = m_cnt + 1;
      if (rel && !cmt) m_cnt = m_cnt - 1;
    end
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_data = '0; wr_last = 0; rd_en = 0; rd_addr = '0; rd_done = 0;
  endtask

  // Drives a frame of len random words, wr_last on the final one; words returned in w.
  task automatic write_frame(input int len, input bit last, output logic [DW-1:0] w [DEPTH]);
    for (int i = 0; i < len; i++) begin
      wr_valid = 1; wr_data = DW'($urandom); wr_last = last && (i == len - 1);
      w[i] = wr_data;
      tick();
    end
    wr_valid = 0; wr_last = 0;
  endtask

  task automatic pulse_done();
    rd_done = 1; tick(); rd_done = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
    n_cmp++; if (bank_cnt !== 2'd0) begin n_err++; $display("FAIL reset_bank_cnt: got %0d want 0", bank_cnt); end
    n_cmp++; if (rd_bank_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_bank_valid: got %b want 0", rd_bank_valid); end
    n_cmp++; if (rd_data_valid !== 1'b0 || rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got v=%b d=%h want v=0 d=00", rd_data_valid, rd_data); end
    rst_n = 1;
    tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_data = 8'h10 + DW'(i); wr_last = (i == 4);
      tick();
    end
    wr_valid = 0; wr_last = 0;
    n_cmp++; if (bank_cnt !== 2'd1 || rd_bank_valid !== 1'b1) begin n_err++; $display("FAIL single_commit: got cnt=%0d v=%b want cnt=1 v=1", bank_cnt, rd_bank_valid); end
`ifdef PQ_BUF_WLEN_EN
    n_cmp++; if (rd_len !== 5'd5) begin n_err++; $display("FAIL single_rd_len: got %0d want 5", rd_len); end
`endif
    for (int c = 0; c < 7; c++) begin
      rd_en = (c < 5); rd_addr = AW'(c);
      tick();
      n_cmp++;
      if (rd_data_valid !== (c >= 1 && c <= 5) || ((c >= 1 && c <= 5) && rd_data !== 8'h10 + DW'(c - 1))) begin
        n_err++; $display("FAIL single_read c=%0d: got v=%b d=%h want v=%b d=%h", c, rd_data_valid, rd_data, (c >= 1 && c <= 5), 8'h10 + DW'(c - 1));
      end
    end
    rd_en = 0;
    pulse_done();
    n_cmp++; if (bank_cnt !== 2'd0) begin n_err++; $display("FAIL single_release: got %0d want 0", bank_cnt); end
  endtask

  task automatic test_full_backpressure();
    logic [DW-1:0] w [DEPTH];
    write_frame($urandom_range(1, 16), 1, w);
    write_frame($urandom_range(1, 16), 1, w);
    n_cmp++; if (bank_cnt !== 2'd2 || wr_ready !== 1'b0) begin n_err++; $display("FAIL full_state: got cnt=%0d rdy=%b want cnt=2 rdy=0", bank_cnt, wr_ready); end
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = DW'($urandom); wr_last = 1;
      tick();
      n_cmp++; if (bank_cnt !== 2'd2) begin n_err++; $display("FAIL full_hold: got %0d want 2", bank_cnt); end
    end
    wr_valid = 0; wr_last = 0;
    for (int a = 0; a < DEPTH + 2; a++) begin
      rd_en = (a < DEPTH); rd_addr = AW'(a);
      tick();
      n_cmp++;
      if (rd_data_valid !== e_dv || (e_dv && e_k && rd_data !== e_d)) begin
        n_err++; $display("FAIL full_read_old a=%0d: got v=%b d=%h want v=%b d=%h", a, rd_data_valid, rd_data, e_dv, e_d);
      end
    end
    rd_en = 0;
    pulse_done();
    n_cmp++; if (bank_cnt !== 2'd1 || wr_ready !== 1'b1) begin n_err++; $display("FAIL full_release: got cnt=%0d rdy=%b want cnt=1 rdy=1", bank_cnt, wr_ready); end
    for (int a = 0; a < DEPTH + 2; a++) begin
      rd_en = (a < DEPTH); rd_addr = AW'(a);
      tick();
      n_cmp++;
      if (rd_data_valid !== e_dv || (e_dv && e_k && rd_data !== e_d)) begin
        n_err++; $display("FAIL full_read_new a=%0d: got v=%b d=%h want v=%b d=%h", a, rd_data_valid, rd_data, e_dv, e_d);
      end
    end
    rd_en = 0;
    pulse_done();
  endtask

  task automatic test_auto_commit();
    logic [DW-1:0] w [DEPTH];
    logic [DW-1:0] one [DEPTH];
    write_frame(15, 0, w);
    n_cmp++; if (bank_cnt !== 2'd0) begin n_err++; $display("FAIL auto_before: got %0d want 0", bank_cnt); end
    wr_valid = 1; wr_data = DW'($urandom); wr_last = 0;
    w[15] = wr_data;
    tick();
    wr_valid = 0;
    n_cmp++; if (bank_cnt !== 2'd1) begin n_err++; $display("FAIL auto_commit: got %0d want 1", bank_cnt); end
`ifdef PQ_BUF_WLEN_EN
    n_cmp++; if (rd_len !== 5'd16) begin n_err++; $display("FAIL auto_rd_len: got %0d want 16", rd_len); end
`endif
    write_frame(1, 1, one);
    n_cmp++; if (bank_cnt !== 2'd2) begin n_err++; $display("FAIL auto_next: got %0d want 2", bank_cnt); end
    for (int a = 0; a < DEPTH + 2; a++) begin
      rd_en = (a < DEPTH); rd_addr = AW'(a);
      tick();
      if (a >= 1 && a <= DEPTH) begin
        n_cmp++;
        if (rd_data_valid !== 1'b1 || rd_data !== w[a - 1]) begin
          n_err++; $display("FAIL auto_read a=%0d: got v=%b d=%h want v=1 d=%h", a - 1, rd_data_valid, rd_data, w[a - 1]);
        end
      end
    end
    rd_en = 0;
    pulse_done();
    rd_en = 1; rd_addr = '0; tick(); rd_en = 0; tick();
    n_cmp++; if (rd_data_valid !== 1'b1 || rd_data !== one[0]) begin n_err++; $display("FAIL auto_ptr_restart: got v=%b d=%h want v=1 d=%h", rd_data_valid, rd_data, one[0]); end
    pulse_done();
  endtask

  task automatic test_commit_release();
    logic [DW-1:0] a_w [DEPTH];
    logic [DW-1:0] b_w [DEPTH];
    write_frame(3, 1, a_w);
    write_frame(2, 0, b_w);
    wr_valid = 1; wr_data = DW'($urandom); wr_last = 1; rd_done = 1;
    b_w[2] = wr_data;
    tick();
    wr_valid = 0; wr_last = 0; rd_done = 0;
    n_cmp++; if (bank_cnt !== 2'd1) begin n_err++; $display("FAIL cr_bank_cnt: got %0d want 1", bank_cnt); end
    for (int a = 0; a < 5; a++) begin
      rd_en = (a < 3); rd_addr = AW'(a);
      tick();
      if (a >= 1 && a <= 3) begin
        n_cmp++;
        if (rd_data_valid !== 1'b1 || rd_data !== b_w[a - 1]) begin
          n_err++; $display("FAIL cr_read a=%0d: got v=%b d=%h want v=1 d=%h", a - 1, rd_data_valid, rd_data, b_w[a - 1]);
        end
      end
    end
    rd_en = 0;
    pulse_done();
  endtask

  task automatic test_read_release();
    logic [DW-1:0] w [DEPTH];
    write_frame(6, 1, w);
    rd_en = 1; rd_addr = 4'd3; rd_done = 1;
    tick();
    rd_en = 0; rd_done = 0;
    n_cmp++; if (bank_cnt !== 2'd0 || rd_bank_valid !== 1'b0) begin n_err++; $display("FAIL rr_release: got cnt=%0d v=%b want cnt=0 v=0", bank_cnt, rd_bank_valid); end
    tick();
    n_cmp++; if (rd_data_valid !== 1'b1 || rd_data !== w[3]) begin n_err++; $display("FAIL rr_data: got v=%b d=%h want v=1 d=%h", rd_data_valid, rd_data, w[3]); end
    tick();
    n_cmp++; if (rd_data_valid !== 1'b0) begin n_err++; $display("FAIL rr_single_pulse: got v=%b want 0", rd_data_valid); end
  endtask

  task automatic test_mid_frame_reset();
    logic [DW-1:0] w [DEPTH];
    write_frame(7, 0, w);
    rst_n = 0;
    tick();
    n_cmp++; if (bank_cnt !== 2'd0 || rd_bank_valid !== 1'b0 || wr_ready !== 1'b0) begin n_err++; $display("FAIL mr_state: got cnt=%0d v=%b rdy=%b want 0 0 0", bank_cnt, rd_bank_valid, wr_ready); end
    n_cmp++; if (rd_data_valid !== 1'b0 || rd_data !== 8'h00) begin n_err++; $display("FAIL mr_rd_data: got v=%b d=%h want v=0 d=00", rd_data_valid, rd_data); end
    rst_n = 1;
    wr_valid = 1; wr_data = 8'hA5; wr_last = 1;
    tick();
    wr_valid = 0; wr_last = 0;
    n_cmp++; if (bank_cnt !== 2'd1) begin n_err++; $display("FAIL mr_commit: got %0d want 1", bank_cnt); end
`ifdef PQ_BUF_WLEN_EN
    n_cmp++; if (rd_len !== 5'd1) begin n_err++; $display("FAIL mr_rd_len: got %0d want 1", rd_len); end
`endif
    rd_en = 1; rd_addr = 4'd0; tick();
    rd_addr = 4'd1; tick();
    rd_en = 0;
    n_cmp++; if (rd_data_valid !== 1'b1 || rd_data !== 8'hA5) begin n_err++; $display("FAIL mr_addr0: got v=%b d=%h want v=1 d=a5", rd_data_valid, rd_data); end
    tick();
    n_cmp++; if (rd_data_valid !== 1'b1 || rd_data !== w[1]) begin n_err++; $display("FAIL mr_stale_addr1: got v=%b d=%h want v=1 d=%h", rd_data_valid, rd_data, w[1]); end
    pulse_done();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = DW'($urandom);
      wr_last  = ($urandom_range(0, 4) == 0);
      rd_en    = ($urandom_range(0, 1) != 0);
      rd_addr  = AW'($urandom);
      rd_done  = ($urandom_range(0, 5) == 0);
      tick();
      n_cmp++;
      if (bank_cnt !== 2'(m_cnt) || rd_bank_valid !== (m_cnt != 0) || wr_ready !== (rst_n && m_cnt < NB)) begin
        n_err++; $display("FAIL rand_ctrl c=%0d: got cnt=%0d v=%b rdy=%b want cnt=%0d v=%b rdy=%b", c, bank_cnt, rd_bank_valid, wr_ready, m_cnt, (m_cnt != 0), (rst_n && m_cnt < NB));
      end
      n_cmp++;
      if (rd_data_valid !== e_dv || (e_dv && e_k && rd_data !== e_d)) begin
        n_err++; $display("FAIL rand_data c=%0d: got v=%b d=%h want v=%b d=%h", c, rd_data_valid, rd_data, e_dv, e_d);
      end
`ifdef PQ_BUF_WLEN_EN
      n_cmp++;
      if (rd_len !== 5'((m_cnt != 0) ? m_len[m_rb] : 0)) begin
        n_err++; $display("FAIL rand_rd_len c=%0d: got %0d want %0d", c, rd_len, (m_cnt != 0) ? m_len[m_rb] : 0);
      end
`endif
    end
    idle_inputs();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_frame();
    test_full_backpressure();
    test_auto_commit();
    test_commit_release();
    test_read_release();
    test_mid_frame_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
